// File: rtl/lvm_data_mem.sv
// lvm_data_mem: data-side memory responder for the lvm-16 CPU.
//
// Serves CPU loads/stores to a word RAM and exposes a small I/O page:
//   0x0000..RAM_DEPTH-1  RAM (not cleared by reset)
//   0x6000               TX: store pushes din into the output FIFO, reads 0
//   0x6001               STATUS: {overflow, full, empty, 8'b0, count[4:0]}
//                        any store clears the sticky overflow bit
//   0x6002               TIMER (only when LVM_DATA_MEM_TIMER_EN is defined)
//   everything else      reads 0, stores ignored
//
// Optional feature macro: LVM_DATA_MEM_TIMER_EN (free-running 16-bit timer).
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   reset     synchronous active-high reset
//   addr      CPU data address
//   din       CPU store data
//   write     CPU store strobe
//   data      combinational load data back to the CPU
//   tx_data   FIFO head word (0 when empty)
//   tx_valid  FIFO non-empty
//   tx_ready  consumer accepts the head word this cycle

module lvm_data_mem #(
    parameter int unsigned RAM_DEPTH  = 16384,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [15:0] din,
    input  logic        write,
    output logic [15:0] data,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned RamAw = $clog2(RAM_DEPTH);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

    localparam logic [16:0] RamTop     = 17'(RAM_DEPTH);
    localparam logic [15:0] AddrTx     = 16'h6000;
    localparam logic [15:0] AddrStatus = 16'h6001;
    localparam logic [15:0] AddrTimer  = 16'h6002;

    logic [15:0] ram [RAM_DEPTH];
    logic [15:0] fifo_q [FIFO_DEPTH];

    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic            overflow_q;

    logic ram_sel, tx_store, status_store;
    logic full, empty, pop, push;
    logic [15:0] status;

    assign ram_sel      = ({1'b0, addr} < RamTop);
    assign tx_store     = write && (addr == AddrTx);
    assign status_store = write && (addr == AddrStatus);

    assign full     = (count_q == CntW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign tx_valid = !empty;
    assign tx_data  = empty ? 16'h0000 : fifo_q[rd_ptr_q];

    assign pop  = tx_valid && tx_ready;
    // A full FIFO still accepts a push when the head leaves in the same edge.
    assign push = tx_store && (!full || pop);

    assign status = {overflow_q, full, empty, 8'h00, 5'(count_q)};

`ifdef LVM_DATA_MEM_TIMER_EN
    logic [15:0] timer_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= 16'h0000;
        end else if (write && (addr == AddrTimer)) begin
            timer_q <= din;
        end else begin
            timer_q <= timer_q + 16'h0001;
        end
    end
`endif

    // RAM and FIFO storage carry no reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && write && ram_sel) begin
            ram[addr[RamAw-1:0]] <= din;
        end
        if (!reset && push) begin
            fifo_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            // Set has priority over clear.
            if (tx_store && full && !pop) begin
                overflow_q <= 1'b1;
            end else if (status_store) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_comb begin
        data = 16'h0000;
        if (ram_sel) begin
            data = ram[addr[RamAw-1:0]];
        end else if (addr == AddrStatus) begin
            data = status;
        end
`ifdef LVM_DATA_MEM_TIMER_EN
        else if (addr == AddrTimer) begin
            data = timer_q;
        end
`endif
    end

endmodule

// File: tb/tb_lvm_data_mem.sv
module tb_lvm_data_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [15:0] din;
    logic        write;
    logic [15:0] data;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_checks = 0;
    int n_fail   = 0;

    lvm_data_mem #(
        .RAM_DEPTH (16384),
        .FIFO_DEPTH(4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .din     (din),
        .write   (write),
        .data    (data),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs/samples happen 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        addr  = a;
        din   = d;
        write = 1'b1;
        step();
        write = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        write    = 1'b1;
        addr     = 16'h6000;
        din      = 16'h5555;
        tx_ready = 1'b0;
        step();
        reset = 1'b0;
        write = 1'b0;
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tx_valid: got %b want 0", tx_valid);
        end
        n_checks++;
        if (tx_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_tx_data: got %h want 0000", tx_data);
        end
        addr = 16'h6001;
        #1;
        n_checks++;
        if (data !== 16'h2000) begin
            n_fail++;
            $display("FAIL reset_status: got %h want 2000", data);
        end
        addr = 16'h6002;
        #1;
        n_checks++;
        if (data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_timer: got %h want 0000", data);
        end
    endtask

    task automatic test_ram();
        store(16'h0005, 16'h0032);
        addr = 16'h0005;
        #1;
        n_checks++;
        if (data !== 16'h0032) begin
            n_fail++;
            $display("FAIL ram_roundtrip: got %h want 0032", data);
        end
        // Same-cycle load sees the old value.
        addr  = 16'h0005;
        din   = 16'h1234;
        write = 1'b1;
        #1;
        n_checks++;
        if (data !== 16'h0032) begin
            n_fail++;
            $display("FAIL ram_old_value: got %h want 0032", data);
        end
        step();
        write = 1'b0;
        #1;
        n_checks++;
        if (data !== 16'h1234) begin
            n_fail++;
            $display("FAIL ram_new_value: got %h want 1234", data);
        end
        store(16'h3FFF, 16'hA5A5);
        addr = 16'h3FFF;
        #1;
        n_checks++;
        if (data !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL ram_top_word: got %h want a5a5", data);
        end
        // Unmapped stores must not alias into RAM.
        store(16'h4005, 16'hBEEF);
        store(16'h5FFF, 16'hBEEF);
        addr = 16'h5FFF;
        #1;
        n_checks++;
        if (data !== 16'h0000) begin
            n_fail++;
            $display("FAIL ram_unmapped_read: got %h want 0000", data);
        end
        addr = 16'h0005;
        #1;
        n_checks++;
        if (data !== 16'h1234) begin
            n_fail++;
            $display("FAIL ram_no_alias: got %h want 1234", data);
        end
        addr = 16'hFFFF;
        #1;
        n_checks++;
        if (data !== 16'h0000) begin
            n_fail++;
            $display("FAIL ram_high_read: got %h want 0000", data);
        end
        addr = 16'h6000;
        #1;
        n_checks++;
        if (data !== 16'h0000) begin
            n_fail++;
            $display("FAIL tx_read_zero: got %h want 0000", data);
        end
    endtask

    task automatic test_fifo_overflow();
        tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) store(16'h6000, 16'(i));
        addr = 16'h6001;
        #1;
        n_checks++;
        if (data !== 16'hC004) begin
            n_fail++;
            $display("FAIL ovf_status: got %h want c004", data);
        end
        tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== 16'(i)) begin
                n_fail++;
                $display("FAIL ovf_drain_%0d: got valid=%b data=%h want valid=1 data=%h",
                         i, tx_valid, tx_data, 16'(i));
            end
            step();
        end
        n_checks++;
        if (tx_valid !== 1'b0 || tx_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL ovf_empty: got valid=%b data=%h want 0/0000", tx_valid, tx_data);
        end
        addr = 16'h6001;
        #1;
        n_checks++;
        if (data !== 16'hA000) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %h want a000", data);
        end
        store(16'h6001, 16'hFFFF);
        addr = 16'h6001;
        #1;
        n_checks++;
        if (data !== 16'h2000) begin
            n_fail++;
            $display("FAIL ovf_clear: got %h want 2000", data);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_full_pushpop();
        logic [15:0] exp [4];
        exp[0] = 16'h0012;
        exp[1] = 16'h0013;
        exp[2] = 16'h0014;
        exp[3] = 16'h0009;
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) store(16'h6000, 16'h0011 + 16'(i));
        addr = 16'h6001;
        #1;
        n_checks++;
        if (data !== 16'h4004) begin
            n_fail++;
            $display("FAIL full_status: got %h want 4004", data);
        end
        tx_ready = 1'b1;
        store(16'h6000, 16'h0009);
        tx_ready = 1'b0;
        addr     = 16'h6001;
        #1;
        n_checks++;
        if (data !== 16'h4004) begin
            n_fail++;
            $display("FAIL full_pushpop_status: got %h want 4004", data);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (tx_data !== exp[i]) begin
                n_fail++;
                $display("FAIL full_drain_%0d: got %h want %h", i, tx_data, exp[i]);
            end
            step();
        end
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drain_empty: got %b want 0", tx_valid);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        tx_ready = 1'b0;
        addr     = 16'h6000;
        din      = 16'h00AA;
        write    = 1'b1;
        #1;
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_push_before: got %b want 0", tx_valid);
        end
        step();
        write = 1'b0;
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 16'h00AA) begin
            n_fail++;
            $display("FAIL empty_push_after: got valid=%b data=%h want 1/00aa", tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        store(16'h6000, 16'h00BB);
        tx_ready = 1'b0;
        addr     = 16'h6001;
        #1;
        n_checks++;
        if (data !== 16'h0001 || tx_data !== 16'h00BB) begin
            n_fail++;
            $display("FAIL pushpop_mid: got status=%h head=%h want 0001/00bb", data, tx_data);
        end
        tx_ready = 1'b1;
        step();
        step();
        tx_ready = 1'b0;
        #1;
        n_checks++;
        if (data !== 16'h2000) begin
            n_fail++;
            $display("FAIL ready_while_empty: got %h want 2000", data);
        end
    endtask

    task automatic test_reset_mid();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) store(16'h6000, 16'h0040 + 16'(i));
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        addr     = 16'h6001;
        #1;
        n_checks++;
        if (data !== 16'h8003) begin
            n_fail++;
            $display("FAIL mid_pre_status: got %h want 8003", data);
        end
        reset = 1'b1;
        store(16'h6000, 16'h0077);
        reset = 1'b0;
        addr  = 16'h6001;
        #1;
        n_checks++;
        if (data !== 16'h2000 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got status=%h valid=%b want 2000/0", data, tx_valid);
        end
        reset = 1'b1;
        store(16'h0005, 16'hDEAD);
        reset = 1'b0;
        addr  = 16'h0005;
        #1;
        n_checks++;
        if (data !== 16'h1234) begin
            n_fail++;
            $display("FAIL reset_blocks_ram: got %h want 1234", data);
        end
    endtask

    task automatic test_timer();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        addr = 16'h6002;
        #1;
`ifdef LVM_DATA_MEM_TIMER_EN
        n_checks++;
        if (data !== 16'h000A) begin
            n_fail++;
            $display("FAIL timer_count: got %h want 000a", data);
        end
`else
        n_checks++;
        if (data !== 16'h0000) begin
            n_fail++;
            $display("FAIL timer_absent: got %h want 0000", data);
        end
`endif
        store(16'h6002, 16'hFFFF);
        step();
        step();
        addr = 16'h6002;
        #1;
`ifdef LVM_DATA_MEM_TIMER_EN
        n_checks++;
        if (data !== 16'h0001) begin
            n_fail++;
            $display("FAIL timer_wrap: got %h want 0001", data);
        end
`else
        n_checks++;
        if (data !== 16'h0000) begin
            n_fail++;
            $display("FAIL timer_store_ignored: got %h want 0000", data);
        end
`endif
    endtask

    initial begin
        reset    = 1'b0;
        addr     = 16'h0000;
        din      = 16'h0000;
        write    = 1'b0;
        tx_ready = 1'b0;
        #2;
        test_reset();
        test_ram();
        test_fifo_overflow();
        test_full_pushpop();
        test_back_to_back();
        test_reset_mid();
        test_timer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lvm_data_mem.md
Name: lvm_data_mem

Overview:
- Data-side memory responder for the lvm-16 CPU, at the far end of the CPU's addr/out/write/data bus.
- Serves CPU loads and stores to a word RAM.
- Provides a memory-mapped output port. CPU stores are buffered in a small FIFO and drained to an external consumer over a valid/ready handshake.
- Provides a status register and an optional free-running cycle timer.

Parameters:
- RAM_DEPTH, 16384, number of 16-bit RAM words at 0x0000..RAM_DEPTH-1 (power of two, max 0x6000)
- FIFO_DEPTH, 4, output FIFO entries (power of two, 2..16)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- addr  input  16  CPU data address
- din  input  16  CPU store data (the CPU's out bus)
- write  input  1  CPU store strobe, sampled at rising edge
- data  output  16  load data returned to the CPU (combinational)
- tx_data  output  16  FIFO head word
- tx_valid  output  1  FIFO non-empty
- tx_ready  input  1  consumer accepts head this cycle

Behaviour:
- Reset: synchronous, active-high; clk is the only clock.
- Load path:
  - data is a combinational function of addr and current state: zero-latency, valid in the same cycle addr is presented (the CPU consumes it before its next edge).
  - No read side effects.
- Address map:
  - 0x0000..RAM_DEPTH-1: RAM. Read returns the stored word. Store writes din at the edge.
  - RAM_DEPTH..0x5FFF: unmapped. Reads return 0; stores are ignored.
  - 0x6000 TX: store pushes din into the FIFO; read returns 0.
  - 0x6001 STATUS: bit15 overflow (sticky), bit14 full, bit13 empty, bits[4:0] count, other bits 0. Any store clears overflow; din is ignored.
  - 0x6002 TIMER: see Optional Feature.
  - 0x6003..0xFFFF: reads return 0; stores are ignored.
- RAM:
  - Contents are not cleared by reset.
  - A load of an address in the same cycle as a store to it returns the old value; the new value is visible from the next cycle.
- FIFO:
  - Push when write=1, addr=0x6000, and the FIFO is not full.
  - Pop when tx_valid and tx_ready are both high at the edge.
  - tx_valid = (count != 0).
  - tx_data = head word when non-empty, 0 when empty.
  - count range 0..FIFO_DEPTH; read/write pointers wrap modulo FIFO_DEPTH.
- FIFO boundary cases:
  - Push while full with no pop: word dropped, overflow set to 1, count unchanged.
  - Push while full with a simultaneous pop: both occur, no overflow, count stays FIFO_DEPTH.
  - Push while empty: no bypass; tx_valid rises the cycle after the push edge.
  - Push and pop in the same cycle when non-empty and not full: count unchanged.
  - tx_ready while empty: no effect.
  - Status store in the same cycle that an overflow occurs: overflow ends at 1 (set wins).
- Reset, checked at the rising edge:
  - count=0, pointers=0, overflow=0, timer=0, tx_valid=0, tx_data=0.
  - Reset overrides any push, pop, or store occurring in the same cycle, including RAM stores.
  - Reset mid-drain discards all FIFO contents.
- No state machine beyond the FIFO counters. Design is fully synchronous with no latches.

Optional Feature:
- Macro: LVM_DATA_MEM_TIMER_EN.
- Defined:
  - 16-bit TIMER increments every clk edge when not in reset and wraps 0xFFFF->0x0000.
  - Read at 0x6002 returns the current value.
  - A store at 0x6002 loads din; the next edge resumes incrementing from din.
- Undefined: no timer register. 0x6002 reads return 0 and stores are ignored.

Test Plan:
- RAM round trip: store 0x0032 to 0x0005, then read 0x0005 -> data=0x0032. Read 0x5FFF -> data=0x0000. Read of 0x0005 in the store cycle -> old value.
- FIFO fill and overflow (FIFO_DEPTH=4, tx_ready=0): store 1,2,3,4,5 to 0x6000 -> STATUS=0xC004 (overflow, full, count 4). Then drive tx_ready=1 -> tx_data sequence 1,2,3,4, then tx_valid=0 and STATUS=0xA000.
- Full plus simultaneous push/pop: with FIFO full and tx_ready=1, store 0x0009 -> overflow stays 0, count stays 4, 0x0009 appears as the last word drained.
- Empty push latency: store 0x00AA to 0x6000 at edge N -> tx_valid=0 before edge N, tx_valid=1 and tx_data=0x00AA after edge N.
- Reset mid-operation: FIFO holding 3 words with overflow=1, assert reset for one edge together with a TX store -> STATUS=0x2000, tx_valid=0, pushed word lost. Previously written RAM word is unchanged.
- Timer (macro defined): after reset, 10 edges -> read 0x6002 = 0x000A. Store 0xFFFF, then 2 edges -> 0x0001. With the macro undefined -> 0x0000.
